// File: rtl/cc_tag_refill.sv
// Sweeps the tag SRAM to invalid after reset, then refills one line per miss (AR/R -> data SRAM -> tag commit).
// Latency: 1 (REQ) + BEATS + 1 (TAG) cycles after capture, excluding AR/R stalls.
// Backpressure: AR held stable until ar_ready_i; beats are consumed only on r_valid_i.
module cc_tag_refill #(
    parameter int TAG_W  = 17,
    parameter int IDX_W  = 9,
    parameter int OFF_W  = 6,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 miss_i,
    input  logic [TAG_W-1:0]     tag_i,
    input  logic [IDX_W-1:0]     index_i,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    output logic [31:0]          araddr_o,
    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    input  logic [DATA_W-1:0]    r_data_i,
    input  logic                 r_last_i,
    output logic                 data_wren_o,
    output logic [IDX_W+3-1:0]   data_waddr_o,
    output logic [DATA_W-1:0]    data_wdata_o,
    output logic                 tag_wren_o,
    output logic [IDX_W-1:0]     tag_waddr_o,
    output logic [TAG_W:0]       tag_wdata_o,
    output logic                 init_done_o,
    output logic                 busy_o,
    output logic                 fill_done_o,
    output logic                 proto_err_o
);

    typedef enum logic [2:0] {INIT, IDLE, REQ, DATA, TAG} state_t;

    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    state_t               state_q, state_d;
    logic                 armed_q;
    logic [IDX_W-1:0]     sweep_q;
    logic                 init_done_q;
    logic [TAG_W-1:0]     cap_tag_q;
    logic [IDX_W-1:0]     cap_idx_q;
    logic [2:0]           beat_q;
    logic                 proto_err_q;
    logic [IDX_W+3-1:0]   data_waddr_q;
    logic [DATA_W-1:0]    data_wdata_q;
    logic [IDX_W-1:0]     tag_waddr_q;
    logic [TAG_W:0]       tag_wdata_q;

    logic sweep_wr;
    logic beat_fire;

    // armed_q keeps every output low while reset is held, including the INIT sweep writes.
    assign sweep_wr  = (state_q == INIT) && armed_q;
    assign beat_fire = (state_q == DATA) && r_valid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (sweep_wr && (sweep_q == '1)) state_d = IDLE;
            IDLE:    if (miss_i && init_done_q) state_d = REQ;
            REQ:     if (ar_ready_i) state_d = DATA;
            DATA:    if (beat_fire && (beat_q == LAST_BEAT)) state_d = TAG;
            TAG:     state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        ar_valid_o   = (state_q == REQ);
        araddr_o     = {cap_tag_q, cap_idx_q, {OFF_W{1'b0}}};
        r_ready_o    = (state_q == DATA);
        fill_done_o  = (state_q == TAG);
        busy_o       = armed_q && (state_q != IDLE);
        init_done_o  = init_done_q;
        proto_err_o  = proto_err_q;

        data_wren_o  = beat_fire;
        data_waddr_o = data_waddr_q;
        data_wdata_o = data_wdata_q;
        if (beat_fire) begin
            data_waddr_o = {cap_idx_q, beat_q};
            data_wdata_o = r_data_i;
        end

        tag_wren_o  = sweep_wr || (state_q == TAG);
        tag_waddr_o = tag_waddr_q;
        tag_wdata_o = tag_wdata_q;
        if (sweep_wr) begin
            tag_waddr_o = sweep_q;
            tag_wdata_o = '0;
        end else if (state_q == TAG) begin
            tag_waddr_o = cap_idx_q;
            tag_wdata_o = {1'b1, cap_tag_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            armed_q      <= 1'b0;
            sweep_q      <= '0;
            init_done_q  <= 1'b0;
            cap_tag_q    <= '0;
            cap_idx_q    <= '0;
            beat_q       <= '0;
            proto_err_q  <= 1'b0;
            data_waddr_q <= '0;
            data_wdata_q <= '0;
            tag_waddr_q  <= '0;
            tag_wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;

            if (sweep_wr) begin
                sweep_q <= sweep_q + 1'b1;
                if (sweep_q == '1) init_done_q <= 1'b1;
            end

            if ((state_q == IDLE) && miss_i && init_done_q) begin
                cap_tag_q <= tag_i;
                cap_idx_q <= index_i;
            end

            if ((state_q == REQ) && ar_ready_i) beat_q <= '0;
            else if (beat_fire) beat_q <= beat_q + 1'b1;

            // r_last_i is only checked; the line length is fixed by the beat count.
            if (beat_fire && (r_last_i != (beat_q == LAST_BEAT))) proto_err_q <= 1'b1;

            if (data_wren_o) begin
                data_waddr_q <= data_waddr_o;
                data_wdata_q <= data_wdata_o;
            end
            if (tag_wren_o) begin
                tag_waddr_q <= tag_waddr_o;
                tag_wdata_q <= tag_wdata_o;
            end
        end
    end

endmodule

// File: tb/tb_cc_tag_refill.sv
module tb_cc_tag_refill;

    localparam int TAG_W  = 17;
    localparam int IDX_W  = 9;
    localparam int OFF_W  = 6;
    localparam int DATA_W = 64;
    localparam int BEATS  = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                miss_i = 1'b0;
    logic [TAG_W-1:0]    tag_i = '0;
    logic [IDX_W-1:0]    index_i = '0;
    logic                ar_valid_o;
    logic                ar_ready_i = 1'b0;
    logic [31:0]         araddr_o;
    logic                r_valid_i = 1'b0;
    logic                r_ready_o;
    logic [DATA_W-1:0]   r_data_i = '0;
    logic                r_last_i = 1'b0;
    logic                data_wren_o;
    logic [IDX_W+2:0]    data_waddr_o;
    logic [DATA_W-1:0]   data_wdata_o;
    logic                tag_wren_o;
    logic [IDX_W-1:0]    tag_waddr_o;
    logic [TAG_W:0]      tag_wdata_o;
    logic                init_done_o;
    logic                busy_o;
    logic                fill_done_o;
    logic                proto_err_o;

    cc_tag_refill #(
        .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .DATA_W(DATA_W), .BEATS(BEATS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .miss_i(miss_i), .tag_i(tag_i), .index_i(index_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .araddr_o(araddr_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_last_i(r_last_i),
        .data_wren_o(data_wren_o), .data_waddr_o(data_waddr_o), .data_wdata_o(data_wdata_o),
        .tag_wren_o(tag_wren_o), .tag_waddr_o(tag_waddr_o), .tag_wdata_o(tag_wdata_o),
        .init_done_o(init_done_o), .busy_o(busy_o), .fill_done_o(fill_done_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [IDX_W+2:0] addr; logic [DATA_W-1:0] data; } dwr_t;
    typedef struct { logic [IDX_W-1:0] addr; logic [TAG_W:0] data; } twr_t;

    dwr_t exp_dq[$];
    twr_t exp_tq[$];

    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write-port scoreboard: every SRAM write must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_wren_o && tag_wren_o) chk("wr_collision", 1, 0);
            if (data_wren_o) begin
                if (exp_dq.size() == 0) chk("unexpected_data_wr", {52'd0, data_waddr_o}, 0);
                else begin
                    dwr_t e;
                    e = exp_dq.pop_front();
                    chk("data_waddr", {52'd0, data_waddr_o}, {52'd0, e.addr});
                    chk("data_wdata", data_wdata_o, e.data);
                end
            end
            if (tag_wren_o) begin
                if (exp_tq.size() == 0) chk("unexpected_tag_wr", {55'd0, tag_waddr_o}, 0);
                else begin
                    twr_t e;
                    e = exp_tq.pop_front();
                    chk("tag_waddr", {55'd0, tag_waddr_o}, {55'd0, e.addr});
                    chk("tag_wdata", {46'd0, tag_wdata_o}, {46'd0, e.data});
                end
            end
        end
    end

    task automatic push_sweep();
        for (int i = 0; i < (1 << IDX_W); i++) begin
            twr_t t;
            t.addr = IDX_W'(i);
            t.data = '0;
            exp_tq.push_back(t);
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!init_done_o && n < 600) begin
            step();
            n++;
        end
        chk({name, "_init_done"}, {63'd0, init_done_o}, 1);
        chk({name, "_busy_after_init"}, {63'd0, busy_o}, 0);
        chk({name, "_sweep_len"}, exp_tq.size(), 0);
    endtask

    // One refill. last_beat marks where r_last_i is driven; abort_beat >= 0 asserts reset on that beat.
    task automatic do_fill(input logic [TAG_W-1:0] tg, input logic [IDX_W-1:0] ix,
                           input int stall, input bit gaps, input int last_beat,
                           input int abort_beat, input int exp_lat);
        logic [DATA_W-1:0] d [BEATS];
        int n;
        int lat;
        for (int b = 0; b < BEATS; b++) begin
            d[b] = {$urandom, $urandom};
            if (abort_beat < 0 || b < abort_beat) begin
                dwr_t w;
                w.addr = {ix, 3'(b)};
                w.data = d[b];
                exp_dq.push_back(w);
            end
        end
        if (abort_beat < 0) begin
            twr_t t;
            t.addr = ix;
            t.data = {1'b1, tg};
            exp_tq.push_back(t);
        end
        miss_i = 1'b1;
        tag_i = tg;
        index_i = ix;
        n = 0;
        step();
        while (!ar_valid_o && n < 20) begin
            step();
            n++;
        end
        chk("ar_valid_seen", {63'd0, ar_valid_o}, 1);
        lat = 0;
        for (int k = 0; k < stall; k++) begin
            chk("ar_hold_valid", {63'd0, ar_valid_o}, 1);
            chk("ar_hold_addr", {32'd0, araddr_o}, {32'd0, tg, ix, 6'd0});
            chk("no_r_ready_in_req", {63'd0, r_ready_o}, 0);
            step();
            lat++;
        end
        chk("araddr", {32'd0, araddr_o}, {32'd0, tg, ix, 6'd0});
        ar_ready_i = 1'b1;
        step();
        lat++;
        ar_ready_i = 1'b0;
        chk("r_ready_in_data", {63'd0, r_ready_o}, 1);
        for (int b = 0; b < BEATS; b++) begin
            if (gaps) begin
                r_valid_i = 1'b0;
                step();
                lat++;
            end
            r_valid_i = 1'b1;
            r_data_i = d[b];
            r_last_i = (b == last_beat);
            if (b == abort_beat) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_outs_zero", {52'd0, ar_valid_o, r_ready_o, data_wren_o, tag_wren_o,
                     init_done_o, busy_o, fill_done_o, proto_err_o, |data_waddr_o,
                     |data_wdata_o, |tag_waddr_o, |tag_wdata_o}, 0);
                r_valid_i = 1'b0;
                r_last_i = 1'b0;
                miss_i = 1'b0;
                return;
            end
            if ((b == last_beat) != (b == BEATS - 1)) exp_err = 1'b1;
            step();
            lat++;
            r_valid_i = 1'b0;
            r_last_i = 1'b0;
            chk("proto_err", {63'd0, proto_err_o}, {63'd0, exp_err});
        end
        chk("fill_done_pulse", {63'd0, fill_done_o}, 1);
        if (exp_lat > 0) chk("fill_latency", lat, exp_lat);
        miss_i = 1'b0;
        step();
        chk("fill_done_single", {63'd0, fill_done_o}, 0);
        chk("idle_after_fill", {63'd0, busy_o}, 0);
        chk("data_q_drained", exp_dq.size(), 0);
        chk("tag_q_drained", exp_tq.size(), 0);
    endtask

    initial begin
        #3;
        chk("reset_outs", {54'd0, ar_valid_o, r_ready_o, data_wren_o, tag_wren_o,
             init_done_o, busy_o, fill_done_o, proto_err_o, |araddr_o, |tag_wdata_o}, 0);
        push_sweep();
        step();
        rst_n = 1'b1;
        // A miss during the sweep must be ignored.
        miss_i = 1'b1;
        tag_i = 17'h00F0F;
        index_i = 9'h033;
        step();
        step();
        chk("busy_in_init", {63'd0, busy_o}, 1);
        chk("no_ar_in_init", {63'd0, ar_valid_o}, 0);
        miss_i = 1'b0;
        wait_init("boot");

        do_fill(17'h1ABCD, 9'h05A, 0, 1'b0, 7, -1, 9);
        do_fill(17'h0_1234, 9'h1C7, 5, 1'b0, 7, -1, 0);
        do_fill(17'h1_FFFF, 9'h1FF, 0, 1'b1, 7, -1, 0);
        do_fill(17'h0_5555, 9'h000, 2, 1'b0, 3, -1, 0);
        chk("proto_err_sticky", {63'd0, proto_err_o}, 1);
        do_fill(17'h0_AAAA, 9'h101, 0, 1'b0, 7, -1, 0);
        chk("proto_err_still", {63'd0, proto_err_o}, 1);

        do_fill(17'h0_7777, 9'h0EE, 0, 1'b0, 7, 4, 0);
        step();
        step();
        exp_err = 1'b0;
        chk("abort_data_q", exp_dq.size(), 0);
        push_sweep();
        rst_n = 1'b1;
        step();
        chk("proto_err_cleared", {63'd0, proto_err_o}, 0);
        wait_init("rerun");
        do_fill(17'h1_2345, 9'h0EE, 1, 1'b1, 7, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "FAIL timeout");
    end

endmodule

// File: doc/cc_tag_refill.md
Name: cc_tag_refill

Overview:
- Write-side counterpart of the cache tag lookup path.
- After reset, sweeps every tag SRAM entry to invalid.
- On each miss from the controller:
  - fetches the 64-byte line from memory over an AR/R read channel;
  - writes the beats into the data SRAM;
  - commits {valid, tag} into the tag SRAM entry that the lookup path later reads.

Parameters:
- TAG_W, 17, tag width
- IDX_W, 9, index width (2^IDX_W sets)
- OFF_W, 6, byte offset width (line = 2^OFF_W bytes)
- DATA_W, 64, R-channel beat width
- BEATS, 8, beats per line (2^OFF_W*8/DATA_W)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- miss_i  input  1  level; controller holds high until fill_done_o
- tag_i  input  TAG_W  miss tag, valid while miss_i
- index_i  input  IDX_W  miss set index, valid while miss_i
- ar_valid_o  output  1  read address valid
- ar_ready_i  input  1  read address ready
- araddr_o  output  32  {tag, index, OFF_W'b0}
- r_valid_i  input  1  read data valid
- r_ready_o  output  1  read data ready
- r_data_i  input  DATA_W  read data
- r_last_i  input  1  last beat marker
- data_wren_o  output  1  data SRAM write enable
- data_waddr_o  output  IDX_W+3  {index, beat}
- data_wdata_o  output  DATA_W  beat data
- tag_wren_o  output  1  tag SRAM write enable
- tag_waddr_o  output  IDX_W  tag SRAM address
- tag_wdata_o  output  TAG_W+1  {valid, tag}; valid is MSB
- init_done_o  output  1  high once the invalidation sweep is complete
- busy_o  output  1  high in INIT, REQ, DATA, TAG
- fill_done_o  output  1  one-cycle pulse on tag commit
- proto_err_o  output  1  sticky r_last mismatch flag

Behaviour:
- Reset values: all outputs 0; state INIT; sweep counter 0.
- INIT:
  - Each cycle: tag_wren_o=1, tag_waddr_o=counter, tag_wdata_o=0; counter increments.
  - After writing entry 2^IDX_W-1: init_done_o=1, go to IDLE.
  - Exactly 2^IDX_W write cycles.
  - miss_i is ignored during INIT.
- IDLE:
  - If miss_i && init_done_o: capture tag_i/index_i into registers, go to REQ.
  - Capture is one cycle after sampling; no other outputs are asserted.
- REQ:
  - ar_valid_o=1; araddr_o is driven from the captured registers.
  - ar_valid_o and araddr_o stay stable until ar_valid_o && ar_ready_i, then go to DATA with beat counter 0.
- DATA:
  - r_ready_o=1.
  - On each r_valid_i, same cycle: data_wren_o=1, data_waddr_o={index, beat}, data_wdata_o=r_data_i; beat counter increments.
  - r_last_i on a beat other than BEATS-1, or missing on beat BEATS-1: set proto_err_o (cleared only by reset).
  - Termination is by count, not r_last_i: after beat BEATS-1, go to TAG.
- TAG (one cycle):
  - tag_wren_o=1, tag_waddr_o=index, tag_wdata_o={1'b1, tag}, fill_done_o=1.
  - Go to IDLE.
- No new miss is accepted in the same cycle as fill_done_o. A miss_i still high the cycle after TAG is treated as a new request; the controller must drop it on fill_done_o.
- Outside the states above, write enables are 0 and address/data outputs hold their last value.
- Reset asserted mid-fill: aborts immediately. The line may be partially written but the tag is never committed; the INIT sweep reruns after reset release.
- Data SRAM and tag SRAM writes never occur in the same cycle.
- Fill latency, excluding AR/R stalls: 1 (REQ) + BEATS + 1 (TAG) cycles after capture.

Test Plan:
- Reset release: tag_wren_o high for exactly 512 cycles, addresses 0..511, wdata 0; then init_done_o=1, busy_o=0.
- Miss tag=17'h1ABCD, index=9'h05A, ar_ready_i high:
  - araddr_o=32'hD5E6_9680;
  - 8 data writes at addresses 0x2D0..0x2D7 in order;
  - then tag_wren_o with addr 0x05A, wdata 18'h3ABCD, fill_done_o pulse.
- ar_ready_i low for 5 cycles: ar_valid_o and araddr_o held constant for 5 cycles; no r_ready_o until the handshake.
- r_valid_i toggling 1,0,1,0...: exactly 8 data writes, one per valid beat; data_waddr_o increments only on valid beats.
- r_last_i asserted on beat 3: proto_err_o=1 from the next cycle and stays set; fill still completes after 8 beats.
- rst_n low during beat 4: all outputs 0 asynchronously; no tag write for that index; full 512-entry sweep repeats.
